// File: rtl/filt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filt_seq_pkg
// Purpose  : Shared state encoding and parameter defaults for the click-free
//            filter-mode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package filt_seq_pkg;

  // Sequencer phases around a filter-mode change
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    RAMP_DN = 3'd1,
    SWITCH  = 3'd2,
    FLUSH   = 3'd3,
    RAMP_UP = 3'd4
  } filt_seq_state_t;

  localparam int         c_bit_width_def     = 24;
  localparam int         c_gain_bits_def     = 5;
  localparam int         c_flush_samples_def = 16;
  localparam logic [2:0] c_sel_init_def      = 3'b000;

endpackage
`default_nettype wire

// File: rtl/filt_sel_sequencer_gain_scaler.sv
`default_nettype none
// ============================================================================
// Module   : gain_scaler
// Purpose  : Registered signed gain stage. Scales the filter output by
//            gain/2**GAIN_BITS on every sample strobe and flags the result.
// Revision : 1.0 - initial release
// ============================================================================
module gain_scaler #(
  parameter int BIT_WIDTH = 24,
  parameter int GAIN_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_sample_en,
  input  logic [GAIN_BITS:0]     i_gain,
  input  logic [BIT_WIDTH-1:0]   i_filt_q,
  output logic [BIT_WIDTH-1:0]   o_q,
  output logic                   o_q_valid
);

  // Full product width: signed sample times an unsigned gain of GAIN_BITS+1 bits
  localparam int c_pw = BIT_WIDTH + GAIN_BITS + 1;

  logic [c_pw-1:0]      w_a;
  logic [c_pw-1:0]      w_b;
  logic [c_pw-1:0]      w_prod;
  logic [GAIN_BITS:0]   w_unused_bits;
  logic [BIT_WIDTH-1:0] r_q;
  logic                 r_valid;

  // Both operands extended to the product width so the multiply is exact
  assign w_a    = {{(c_pw-BIT_WIDTH){i_filt_q[BIT_WIDTH-1]}}, i_filt_q};
  assign w_b    = {{(c_pw-GAIN_BITS-1){1'b0}}, i_gain};
  assign w_prod = $signed(w_a) * $signed(w_b);

  // Arithmetic shift by GAIN_BITS then truncate; gain never exceeds unity so
  // the discarded top bit is always a copy of the sign
  assign w_unused_bits = {w_prod[c_pw-1], w_prod[GAIN_BITS-1:0]};

  // Capture the scaled sample on each strobe; valid follows the strobe by one clk
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_sample_en;
      if (i_sample_en) begin
        r_q <= w_prod[BIT_WIDTH+GAIN_BITS-1:GAIN_BITS];
      end
    end
  end

  assign o_q       = r_q;
  assign o_q_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/filt_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : filt_sel_sequencer
// Purpose  : Click-free mode controller for the selectable FIR filter. Ramps
//            the output gain down, switches filter mode, mutes while the
//            delay line flushes, then ramps the gain back up.
// Revision : 1.0 - initial release
// ============================================================================
module filt_sel_sequencer
  import filt_seq_pkg::*;
#(
  parameter int         BIT_WIDTH     = c_bit_width_def,
  parameter int         GAIN_BITS     = c_gain_bits_def,
  parameter int         FLUSH_SAMPLES = c_flush_samples_def,
  parameter logic [2:0] SEL_INIT      = c_sel_init_def
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_sample_en,
  input  logic [2:0]           i_sel_req,
  output logic [2:0]           o_filt_sel,
  input  logic [BIT_WIDTH-1:0] i_filt_q,
  output logic [BIT_WIDTH-1:0] o_q,
  output logic                 o_q_valid,
  output logic                 o_busy
);

  localparam int c_cnt_w = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;

  localparam logic [GAIN_BITS:0] c_gain_one = (GAIN_BITS+1)'(1);
  localparam logic [GAIN_BITS:0] c_gain_max = (GAIN_BITS+1)'(2**GAIN_BITS);
  localparam logic [GAIN_BITS:0] c_gain_pen = c_gain_max - c_gain_one;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FLUSH_SAMPLES-1);

  filt_seq_state_t      r_state;
  logic [GAIN_BITS:0]   r_gain;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_filt_sel;
  logic                 r_busy;
  logic                 w_mismatch;

  assign w_mismatch = (i_sel_req != r_filt_sel);

  // Mode-change sequencer: gain ramps and flush count advance per strobe only
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= FLUSH;
      r_gain     <= '0;
      r_cnt      <= '0;
      r_filt_sel <= SEL_INIT;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mismatch) begin
            r_state <= RAMP_DN;
            r_busy  <= 1'b1;
          end
        end

        RAMP_DN: begin
          // Entry from an early ramp-up abort can arrive with gain already 0;
          // clamp rather than wrap
          if (i_sample_en) begin
            if (r_gain <= c_gain_one) begin
              r_gain  <= '0;
              r_state <= SWITCH;
            end else begin
              r_gain <= r_gain - c_gain_one;
            end
          end
        end

        SWITCH: begin
          r_filt_sel <= i_sel_req;
          r_cnt      <= '0;
          r_state    <= FLUSH;
        end

        FLUSH: begin
          if (i_sample_en) begin
            if (r_cnt == c_cnt_last) begin
              r_cnt   <= '0;
              r_state <= w_mismatch ? SWITCH : RAMP_UP;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
        end

        RAMP_UP: begin
          // A new request wins over a coincident strobe: gain holds this cycle
          if (w_mismatch) begin
            r_state <= RAMP_DN;
          end else if (i_sample_en) begin
            r_gain <= r_gain + c_gain_one;
            if (r_gain == c_gain_pen) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= FLUSH;
          r_gain  <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  gain_scaler #(
    .BIT_WIDTH (BIT_WIDTH),
    .GAIN_BITS (GAIN_BITS)
  ) u_gain_scaler (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_sample_en (i_sample_en),
    .i_gain      (r_gain),
    .i_filt_q    (i_filt_q),
    .o_q         (o_q),
    .o_q_valid   (o_q_valid)
  );

  assign o_filt_sel = r_filt_sel;
  assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_filt_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filt_sel_sequencer
// Purpose  : Randomised scoreboard bench for filt_sel_sequencer against a
//            per-sample behavioural model of the mode-change sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filt_sel_sequencer;

  localparam int BW       = 24;
  localparam int GB       = 5;
  localparam int GMAX     = 32;
  localparam int NFLUSH   = 16;

  localparam int PH_RUN   = 0;
  localparam int PH_DOWN  = 1;
  localparam int PH_SW    = 2;
  localparam int PH_FLUSH = 3;
  localparam int PH_UP    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [2:0]    sel_req = 3'd0;
  logic [BW-1:0] filt_q = '0;
  logic [2:0]    filt_sel;
  logic [BW-1:0] q;
  logic          q_valid;
  logic          busy;

  filt_sel_sequencer #(
    .BIT_WIDTH     (BW),
    .GAIN_BITS     (GB),
    .FLUSH_SAMPLES (NFLUSH),
    .SEL_INIT      (3'b000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_sample_en (sample_en),
    .i_sel_req   (sel_req),
    .o_filt_sel  (filt_sel),
    .i_filt_q    (filt_q),
    .o_q         (q),
    .o_q_valid   (q_valid),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int sel;
    bit busy;
    int hold;
  } st_t;

  st_t st_q[$];
  int  qexp[$];

  int checks = 0;
  int errors = 0;

  // Model of the sequence: mode, gain, muted samples remaining, last output
  int m_phase, m_gain, m_left, m_sel, m_hold;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = PH_FLUSH;
    m_gain  = 0;
    m_left  = NFLUSH;
    m_sel   = 0;
    m_hold  = 0;
  endfunction

  function automatic void model_step(input bit se, input logic [BW-1:0] fq, input logic [2:0] sel);
    int     fqi;
    int     req;
    longint p;
    st_t    s;
    fqi = int'($signed(fq));
    req = int'(sel);
    if (se) begin
      p      = longint'(fqi) * longint'(m_gain);
      p      = p >>> GB;
      m_hold = int'(p);
      qexp.push_back(m_hold);
    end
    case (m_phase)
      PH_RUN:   if (req != m_sel) m_phase = PH_DOWN;
      PH_DOWN:  if (se) begin
                  m_gain = (m_gain > 0) ? m_gain - 1 : 0;
                  if (m_gain == 0) m_phase = PH_SW;
                end
      PH_SW:    begin
                  m_sel   = req;
                  m_left  = NFLUSH;
                  m_phase = PH_FLUSH;
                end
      PH_FLUSH: if (se) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_phase = (req != m_sel) ? PH_SW : PH_UP;
                end
      PH_UP:    if (req != m_sel) m_phase = PH_DOWN;
                else if (se) begin
                  m_gain = m_gain + 1;
                  if (m_gain == GMAX) m_phase = PH_RUN;
                end
      default:  m_phase = PH_FLUSH;
    endcase
    s.valid = se;
    s.sel   = m_sel;
    s.busy  = (m_phase != PH_RUN);
    s.hold  = m_hold;
    st_q.push_back(s);
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge
  task automatic cyc(input bit se, input logic [BW-1:0] fq, input logic [2:0] sel);
    @(negedge clk);
    reset_n   = 1'b1;
    sample_en = se;
    filt_q    = fq;
    sel_req   = sel;
    model_step(se, fq, sel);
  endtask

  task automatic strobe4(input logic [BW-1:0] fq, input logic [2:0] sel);
    cyc(1'b1, fq, sel);
    cyc(1'b0, fq, sel);
    cyc(1'b0, fq, sel);
    cyc(1'b0, fq, sel);
  endtask

  task automatic do_reset(input int n, input logic [2:0] sel);
    st_t s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n   = 1'b0;
      sample_en = 1'b0;
      sel_req   = sel;
      model_reset();
      qexp.delete();
      s.valid = 1'b0;
      s.sel   = 0;
      s.busy  = 1'b1;
      s.hold  = 0;
      st_q.push_back(s);
    end
  endtask

  function automatic logic [BW-1:0] rnd_q();
    logic [31:0] r;
    r = $urandom();
    return r[BW-1:0];
  endfunction

  // Monitor: compare every cycle's status, pop a sample whenever q_valid shows
  initial begin
    st_t s;
    int  e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("q_valid", int'(q_valid), int'(s.valid));
        chk("filt_sel", int'(filt_sel), s.sel);
        chk("busy", int'(busy), int'(s.busy));
        if (q_valid === 1'b1) begin
          if (qexp.size() == 0) begin
            chk("q_unexpected", 1, 0);
          end else begin
            e = qexp.pop_front();
            chk("q_sample", int'($signed(q)), e);
          end
        end else begin
          chk("q_hold", int'($signed(q)), s.hold);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [BW-1:0] fq;
    logic [2:0]    sel;
    logic [31:0]   r;

    model_reset();
    do_reset(3, 3'd0);

    // Power-up: flush, ramp up from zero, settle in RUN
    for (int i = 0; i < 60; i++) strobe4(24'd1000, 3'd0);

    // Full-scale negative input, request mode 3; change to 5 mid-flush
    fq = 24'h800000;
    guard = 0;
    while (!(m_phase == PH_FLUSH && m_left == NFLUSH - 8) && guard < 200) begin
      strobe4(fq, 3'd3);
      guard++;
    end
    chk("reach_flush_a", int'(guard < 200), 1);
    guard = 0;
    while (m_phase != PH_RUN && guard < 200) begin
      strobe4(fq, 3'd5);
      guard++;
    end
    chk("reach_run_a", int'(guard < 200), 1);

    // Request 6, then 2 at the 8th flush strobe: switch is re-entered
    guard = 0;
    while (!(m_phase == PH_FLUSH && m_left == NFLUSH - 8) && guard < 200) begin
      strobe4(24'd123456, 3'd6);
      guard++;
    end
    chk("reach_flush_b", int'(guard < 200), 1);

    // Abort ramp-up at gain 10 with a coincident strobe
    guard = 0;
    while (!(m_phase == PH_UP && m_gain == 10) && guard < 200) begin
      strobe4(24'd123456, 3'd2);
      guard++;
    end
    chk("reach_gain10", int'(guard < 200), 1);
    cyc(1'b1, 24'd123456, 3'd4);
    cyc(1'b0, 24'd123456, 3'd4);
    guard = 0;
    while (m_phase != PH_RUN && guard < 300) begin
      strobe4(24'd123456, 3'd4);
      guard++;
    end
    chk("reach_run_b", int'(guard < 300), 1);

    // Strobe every cycle with random data and occasional new requests
    sel = 3'd4;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom();
      if (r[7:0] == 8'd0) sel = r[10:8];
      cyc(1'b1, rnd_q(), sel);
    end

    // Random strobe density and request changes
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      if (r[9:0] < 10'd6) sel = r[14:12];
      cyc(r[17:16] == 2'd0, rnd_q(), sel);
    end

    // Reset mid-sequence with a mismatching request held
    for (int i = 0; i < 40; i++) cyc(1'b1, rnd_q(), 3'd7);
    do_reset(2, 3'd7);
    for (int i = 0; i < 400; i++) cyc(1'b1, rnd_q(), 3'd7);

    // Settle and make sure every predicted sample was seen
    for (int i = 0; i < 4; i++) cyc(1'b0, 24'd0, 3'd7);
    @(posedge clk);
    #2;
    chk("q_queue_drained", qexp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
